aes128_encrypt_core: RTL and testbench



---
 rtl/aes128_encrypt_core.sv | 191 +++++++++++++++++++
 tb/tb_aes128_encrypt_core.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_encrypt_core.sv
// AES-128 iterative encryptor: one round per clock, on-the-fly key expansion.
// Define AES128_OUT_CLEAR_EN to force the ciphertext output to zero while finish is low.
module aes128_encrypt_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         finish,
    output logic [127:0] AES128_encrypt
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t       st;
    state_t       st_n;
    logic [3:0]   round;
    logic [127:0] sreg;
    logic [127:0] rkey;
    logic [127:0] out_q;
    logic         finish_q;
    logic         load;
    logic         step;
    logic         last;
    logic [7:0]   rcon;
    logic [31:0]  tw;
    logic [31:0]  k0;
    logic [31:0]  k1;
    logic [31:0]  k2;
    logic [31:0]  k3;
    logic [127:0] nkey;
    logic [127:0] sr;
    logic [127:0] mc;
    logic [127:0] res;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] w);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    assign last = (round == 4'd10);

    always_comb begin
        rcon = 8'h00;
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord then SubWord of the last key word.
    assign tw = {sbox(rkey[23:16]), sbox(rkey[15:8]),
                 sbox(rkey[7:0]), sbox(rkey[31:24])}
              ^ {rcon, 24'h0};
    assign k0 = rkey[127:96] ^ tw;
    assign k1 = rkey[95:64] ^ k0;
    assign k2 = rkey[63:32] ^ k1;
    assign k3 = rkey[31:0] ^ k2;
    assign nkey = {k0, k1, k2, k3};

    // SubBytes fused with ShiftRows: row r of column c comes from column c+r.
    always_comb begin
        sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] =
                    sbox(sreg[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    assign mc = {mixcol(sr[127:96]), mixcol(sr[95:64]),
                 mixcol(sr[63:32]), mixcol(sr[31:0])};
    assign res = (last ? sr : mc) ^ nkey;

    always_comb begin
        st_n = st;
        load = 1'b0;
        step = 1'b0;
        unique case (st)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    st_n = RUN;
                end
            end
            RUN: begin
                if (!start) begin
                    st_n = IDLE;
                end else begin
                    step = 1'b1;
                    if (last) begin
                        st_n = DONE;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    st_n = IDLE;
                end
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= IDLE;
            round    <= 4'd0;
            sreg     <= '0;
            rkey     <= '0;
            out_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            st       <= st_n;
            finish_q <= (st_n == DONE);
            if (load) begin
                sreg  <= in ^ key;
                rkey  <= key;
                round <= 4'd1;
            end else if (step) begin
                sreg  <= res;
                rkey  <= nkey;
                round <= round + 4'd1;
            end
            if (step && last) begin
                out_q <= res;
            end
        end
    end

    assign finish = finish_q;

`ifdef AES128_OUT_CLEAR_EN
    assign AES128_encrypt = finish_q ? out_q : 128'h0;
`else
    assign AES128_encrypt = out_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Scoreboard bench for aes128_encrypt_core: known-answer and random blocks
// against a table-free AES-128 model, plus abort and reset boundaries.
module tb_aes128_encrypt_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] pt_in;
    logic [127:0] key_in;
    logic         finish;
    logic [127:0] ct;

    int nvec = 0;
    int nfail = 0;

    logic [127:0] sbq[$];
    logic [127:0] mon_exp;
    logic [127:0] last_ct = '0;
    logic         fin_prev = 1'b0;
    logic [7:0]   sbt[256];

    localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes128_encrypt_core dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in             (pt_in),
        .key            (key_in),
        .finish         (finish),
        .AES128_encrypt (ct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [127:0] k);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [7:0] w[176];
        logic [7:0] tmp[4];
        logic [7:0] a[4];
        logic [7:0] rc;
        logic [7:0] x;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                x = tmp[0];
                tmp[0] = sbt[tmp[1]] ^ rc;
                tmp[1] = sbt[tmp[2]];
                tmp[2] = sbt[tmp[3]];
                tmp[3] = sbt[x];
                rc = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] ^= w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = sbt[s[4*((c+row)%4)+row]];
            for (int c = 0; c < 4; c++) begin
                for (int j = 0; j < 4; j++) a[j] = t[4*c+j];
                if (r < 10) begin
                    s[4*c]   = gm(a[0], 8'h02) ^ gm(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gm(a[1], 8'h02) ^ gm(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gm(a[2], 8'h02) ^ gm(a[3], 8'h03);
                    s[4*c+3] = gm(a[0], 8'h03) ^ a[1] ^ a[2] ^ gm(a[3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = a[j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    function automatic logic [127:0] idle_out(input logic [127:0] v);
`ifdef AES128_OUT_CLEAR_EN
        return 128'h0;
`else
        return v;
`endif
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard monitor: each rising finish consumes one expected block.
    always @(negedge clk) begin
        if (finish && !fin_prev) begin
            if (sbq.size() == 0) begin
                chk("spurious_finish", 128'(1), 128'(0));
            end else begin
                mon_exp = sbq.pop_front();
                chk("ciphertext", ct, mon_exp);
            end
        end
        fin_prev = finish;
    end

    task automatic wait_fin(output int lat, input bit scr);
        int n = 0;
        while (!finish && n < 30) begin
            @(negedge clk);
            n++;
            if (scr) begin
                pt_in  = rand128();
                key_in = rand128();
            end
        end
        lat = n - 1;
    endtask

    task automatic tail(input logic [127:0] exp, input string nm);
        repeat (3) @(negedge clk);
        chk({nm, "_hold_fin"}, 128'(finish), 128'(1));
        chk({nm, "_hold_out"}, ct, exp);
        start = 1'b0;
        @(negedge clk);
        chk({nm, "_drop_fin"}, 128'(finish), 128'(0));
        chk({nm, "_drop_out"}, ct, idle_out(exp));
        last_ct = exp;
        @(negedge clk);
    endtask

    task automatic do_block(input logic [127:0] p, input logic [127:0] k,
                            input logic [127:0] exp, input string nm,
                            input bit scr);
        int lat;
        @(negedge clk);
        start  = 1'b1;
        pt_in  = p;
        key_in = k;
        sbq.push_back(exp);
        wait_fin(lat, scr);
        chk({nm, "_latency"}, 128'(lat), 128'(10));
        tail(exp, nm);
    endtask

    initial begin
        int  lat;
        logic seen;
        logic [127:0] e;
        rst    = 1'b1;
        start  = 1'b0;
        pt_in  = '0;
        key_in = '0;
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b;
            logic [7:0] inv;
            logic [7:0] r;
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                repeat (254) inv = gm(inv, 8'(v));
            end
            b = inv;
            r = inv;
            repeat (4) begin
                b = {b[6:0], b[7]};
                r ^= b;
            end
            sbt[v] = r ^ 8'h63;
        end

        repeat (3) @(negedge clk);
        chk("reset_finish", 128'(finish), 128'(0));
        chk("reset_out", ct, 128'h0);
        rst = 1'b0;

        do_block(128'h6bc1bee22e409f96e93d7e117393172a, K,
                 128'h3ad77bb40d7a3660a89ecaf32466ef97, "kat1", 1'b1);
        do_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, K,
                 128'hf5d3d58503b9699de785895a96fdbaaf, "kat2", 1'b1);
        do_block(128'h30c81c46a35ce411e5fbc1191a0a52ef, K,
                 128'h43b1cd7f598ece23881b00e3ed030688, "kat3", 1'b1);
        do_block(128'hf69f2445df4f9b17ad2b417be66c3710, K,
                 128'h7b0c785e27e8ad3f8223207104725dd4, "kat4", 1'b1);

        // Abort mid-run: no finish, output untouched, then a clean restart.
        @(negedge clk);
        start  = 1'b1;
        pt_in  = 128'h6bc1bee22e409f96e93d7e117393172a;
        key_in = K;
        repeat (4) @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        repeat (12) begin
            @(negedge clk);
            seen |= finish;
        end
        chk("abort_nofinish", 128'(seen), 128'(0));
        chk("abort_out", ct, idle_out(last_ct));
        do_block(128'h6bc1bee22e409f96e93d7e117393172a, K,
                 128'h3ad77bb40d7a3660a89ecaf32466ef97, "restart", 1'b1);

        // Reset while running, start held high throughout.
        @(negedge clk);
        start  = 1'b1;
        pt_in  = rand128();
        key_in = rand128();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_run_finish", 128'(finish), 128'(0));
        chk("rst_run_out", ct, 128'h0);
        rst = 1'b0;
        last_ct = '0;
        e = aes_ref(pt_in, key_in);
        sbq.push_back(e);
        wait_fin(lat, 1'b0);
        chk("rst_run_latency", 128'(lat), 128'(10));
        tail(e, "rst_run");

        // Reset while holding a finished result.
        @(negedge clk);
        start  = 1'b1;
        pt_in  = rand128();
        key_in = rand128();
        e = aes_ref(pt_in, key_in);
        sbq.push_back(e);
        wait_fin(lat, 1'b0);
        chk("pre_rst_latency", 128'(lat), 128'(10));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_done_finish", 128'(finish), 128'(0));
        chk("rst_done_out", ct, 128'h0);
        rst = 1'b0;
        sbq.push_back(e);
        wait_fin(lat, 1'b0);
        chk("rst_done_latency", 128'(lat), 128'(10));
        tail(e, "rst_done");

        for (int i = 0; i < 8; i++) begin
            logic [127:0] p;
            logic [127:0] k;
            p = rand128();
            k = rand128();
            do_block(p, k, aes_ref(p, k), "rand", 1'b1);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(sbq.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
